// File: rtl/pipeline_pkg.sv
// ============================================================
// pipeline_pkg: stage index constants and elaboration helpers
// Rev 1.0
// ============================================================
`default_nettype none

package pipeline_pkg;

  localparam int IF_ID  = 0;
  localparam int ID_EX  = 1;
  localparam int EX_MEM = 2;
  localparam int MEM_WB = 3;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pipeline_stage_cell.sv
// ============================================================
// pipeline_stage_cell: one valid+payload register with load/flush
// Rev 1.0
// ============================================================
`default_nettype none

module pipeline_stage_cell
  import pipeline_pkg::*;
#(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_load,
  input  logic                  i_flush,
  input  logic                  i_valid,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid_nxt
);

  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_data;

  // Flush wins over both hold and load.
  always_comb begin
    o_valid_nxt = r_valid;
    if (i_flush) begin
      o_valid_nxt = 1'b0;
    end else if (i_load) begin
      o_valid_nxt = i_valid;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else begin
      r_valid <= o_valid_nxt;
      if (i_load) begin
        r_data <= i_data;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

`default_nettype wire

// File: rtl/pipeline_stage_chain.sv
// ============================================================
// pipeline_stage_chain: stallable/flushable chain of register stages
// Rev 1.0
// ============================================================
`default_nettype none

module pipeline_stage_chain
  import pipeline_pkg::*;
#(
  parameter int NUM_STAGES = 4,
  parameter int DATA_WIDTH = 64,
  parameter int COLLAPSE   = 0,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                in_valid,
  input  logic [DATA_WIDTH-1:0]               in_data,
  output logic                                in_ready,
  input  logic [NUM_STAGES-1:0]               stall_i,
  input  logic [NUM_STAGES-1:0]               flush_i,
  output logic                                out_valid,
  output logic [DATA_WIDTH-1:0]               out_data,
  input  logic                                out_ready,
  output logic [clog2(NUM_STAGES+1)-1:0]      occupancy_o,
  output logic [CNT_WIDTH-1:0]                retired_o
);

  localparam int OCC_W = clog2(NUM_STAGES + 1);

  logic [NUM_STAGES-1:0] w_valid;
  logic [NUM_STAGES-1:0] w_valid_nxt;
  logic [NUM_STAGES-1:0] w_pass;
  logic [NUM_STAGES-1:0] w_acc;
  logic [DATA_WIDTH-1:0] w_data [NUM_STAGES];
  logic [OCC_W-1:0]      w_occ_nxt;
  logic [OCC_W-1:0]      r_occupancy;
  logic [CNT_WIDTH-1:0]  r_retired;

  assign w_pass = w_valid & ~stall_i & ~flush_i;

  // Acceptance ripples from the consumer back toward stage 0.
  always_comb begin
    logic w_room;
    w_room = out_ready;
    w_acc  = '0;
    for (int s = NUM_STAGES - 1; s >= 0; s--) begin
      if (w_valid[s]) begin
        w_room = w_pass[s] & w_room;
      end else if (COLLAPSE != 0) begin
        w_room = 1'b1;
      end
      w_acc[s] = w_room;
    end
  end

  for (genvar s = 0; s < NUM_STAGES; s++) begin : g_stage
    logic                  w_src_valid;
    logic [DATA_WIDTH-1:0] w_src_data;

    if (s == 0) begin : g_head
      assign w_src_valid = in_valid;
      assign w_src_data  = in_data;
    end else begin : g_body
      assign w_src_valid = w_pass[s-1];
      assign w_src_data  = w_data[s-1];
    end

    pipeline_stage_cell #(
      .DATA_WIDTH (DATA_WIDTH)
    ) u_cell (
      .clk         (clk),
      .reset       (reset),
      .i_load      (w_acc[s]),
      .i_flush     (flush_i[s]),
      .i_valid     (w_src_valid),
      .i_data      (w_src_data),
      .o_valid     (w_valid[s]),
      .o_data      (w_data[s]),
      .o_valid_nxt (w_valid_nxt[s])
    );
  end

  always_comb begin
    w_occ_nxt = '0;
    for (int s = 0; s < NUM_STAGES; s++) begin
      w_occ_nxt = w_occ_nxt + OCC_W'(w_valid_nxt[s]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_occupancy <= '0;
      r_retired   <= '0;
    end else begin
      r_occupancy <= w_occ_nxt;
      if (out_valid && out_ready) begin
        r_retired <= r_retired + CNT_WIDTH'(1);
      end
    end
  end

  assign in_ready    = w_acc[0];
  assign out_valid   = w_pass[NUM_STAGES-1];
  assign out_data    = w_data[NUM_STAGES-1];
  assign occupancy_o = r_occupancy;
  assign retired_o   = r_retired;

endmodule

`default_nettype wire

// File: tb/tb_pipeline_stage_chain.sv
// ============================================================
// tb_pipeline_stage_chain: random + directed bench, non-collapsing and collapsing chains
// Rev 1.0
// ============================================================
`default_nettype none

module tb_pipeline_stage_chain;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic [3:0] stall = '0;
  logic [3:0] flush = '0;
  logic       out_ready = 1'b1;

  logic       ir0, ir1, ov0, ov1;
  logic [7:0] od0, od1;
  logic [2:0] occ0, occ1;
  logic [3:0] ret0;
  logic [7:0] ret1;

  int n_checks = 0;
  int n_errors = 0;

  // Reference: each stage slot holds a payload value or -1 when empty.
  int m_slot [2][4];
  bit m_acc  [2][4];
  int m_ret  [2];
  int m_cw   [2] = '{4, 8};

  always #5 clk = ~clk;

  pipeline_stage_chain #(.NUM_STAGES(4), .DATA_WIDTH(8), .COLLAPSE(0), .CNT_WIDTH(4)) u_dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(ir0),
    .stall_i(stall), .flush_i(flush), .out_valid(ov0), .out_data(od0), .out_ready(out_ready),
    .occupancy_o(occ0), .retired_o(ret0)
  );

  pipeline_stage_chain #(.NUM_STAGES(4), .DATA_WIDTH(8), .COLLAPSE(1), .CNT_WIDTH(8)) u_dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(ir1),
    .stall_i(stall), .flush_i(flush), .out_valid(ov1), .out_data(od1), .out_ready(out_ready),
    .occupancy_o(occ1), .retired_o(ret1)
  );

  task automatic chk(input string tag, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      for (int s = 0; s < 4; s++) m_slot[k][s] = -1;
      m_ret[k] = 0;
    end
  endtask

  // A payload may leave a slot only if it is neither stalled nor flushed and
  // the next slot will have room; empty slots make room (collapse) or pass it on.
  task automatic model_eval(input int k);
    bit room;
    room = out_ready;
    for (int s = 3; s >= 0; s--) begin
      if (m_slot[k][s] >= 0) room = room && !stall[s] && !flush[s];
      else if (k == 1) room = 1'b1;
      m_acc[k][s] = room;
    end
  endtask

  function automatic bit model_ov(input int k);
    return m_slot[k][3] >= 0 && !stall[3] && !flush[3];
  endfunction

  task automatic model_step(input int k);
    int nxt [4];
    for (int s = 0; s < 4; s++) begin
      nxt[s] = m_slot[k][s];
      if (m_acc[k][s]) begin
        if (s == 0) nxt[0] = in_valid ? int'(in_data) : -1;
        else if (m_slot[k][s-1] >= 0 && !stall[s-1] && !flush[s-1]) nxt[s] = m_slot[k][s-1];
        else nxt[s] = -1;
      end
      if (flush[s]) nxt[s] = -1;
    end
    if (model_ov(k) && out_ready) m_ret[k] = (m_ret[k] + 1) % (1 << m_cw[k]);
    for (int s = 0; s < 4; s++) m_slot[k][s] = nxt[s];
  endtask

  task automatic tick();
    #2;
    for (int k = 0; k < 2; k++) begin
      int occ;
      model_eval(k);
      occ = 0;
      for (int s = 0; s < 4; s++) if (m_slot[k][s] >= 0) occ++;
      chk($sformatf("in_ready%0d", k), k ? ir1 : ir0, m_acc[k][0]);
      chk($sformatf("out_valid%0d", k), k ? ov1 : ov0, model_ov(k));
      if (model_ov(k)) chk($sformatf("out_data%0d", k), k ? od1 : od0, m_slot[k][3]);
      chk($sformatf("occupancy%0d", k), k ? occ1 : occ0, occ);
      chk($sformatf("retired%0d", k), k ? ret1 : ret0, m_ret[k]);
    end
    for (int k = 0; k < 2; k++) model_step(k);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0;
    in_data  = '0;
    stall    = '0;
    flush    = '0;
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    #1;
    model_clear();
    chk({tag, "_ov0"}, ov0, 0);
    chk({tag, "_ov1"}, ov1, 0);
    chk({tag, "_occ0"}, occ0, 0);
    chk({tag, "_occ1"}, occ1, 0);
    chk({tag, "_ret0"}, ret0, 0);
    chk({tag, "_ret1"}, ret1, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle_inputs();
  endtask

  initial begin
    model_clear();
    @(posedge clk);
    #1;
    do_reset("rst");
    #1;
    chk("rst_in_ready0", ir0, 1);

    // Three back-to-back payloads emerge four cycles after acceptance.
    in_valid = 1'b1; in_data = 8'h11; tick();
    in_data = 8'h22; tick();
    in_data = 8'h33; tick();
    in_valid = 1'b0; tick();
    #1; chk("lat_c4", od0, 8'h11); chk("lat_v4", ov0, 1); tick();
    #1; chk("lat_c5", od0, 8'h22); tick();
    #1; chk("lat_c6", od0, 8'h33); tick();
    tick();
    chk("lat_ret", ret0, 3);

    // Stall at stage 1 holds A1 and A2 in place and blocks the input.
    do_reset("r2");
    in_valid = 1'b1; in_data = 8'hA1; tick();
    in_data = 8'hA2; tick();
    in_data = 8'hA3; stall = 4'b0010;
    #1; chk("stall_ir0", ir0, 0); chk("stall_ir1", ir1, 0);
    tick();
    #1; chk("stall_occ0", occ0, 2); chk("stall_ir0b", ir0, 0);
    tick();
    #1; chk("stall_occ0b", occ0, 2);
    stall = '0; in_valid = 1'b0;
    for (int i = 0; i < 6; i++) tick();

    // Blocked consumer: only the collapsing chain fills up.
    do_reset("r3");
    out_ready = 1'b0;
    #1; chk("blk_ir0_start", ir0, 0);
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = 8'h55 + 8'(i);
      tick();
    end
    #1;
    chk("blk_occ1", occ1, 4); chk("blk_ir1", ir1, 0); chk("blk_od1", od1, 8'h55);
    chk("blk_occ0", occ0, 0); chk("blk_ir0", ir0, 0);
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 6; i++) tick();

    // Flush beats stall on a valid stage 2.
    do_reset("r4");
    in_valid = 1'b1; in_data = 8'h77; tick();
    in_valid = 1'b0; tick(); tick();
    #1; chk("fl_occ_pre", occ0, 1);
    stall = 4'b0100; flush = 4'b0100; tick();
    #1; chk("fl_occ_post", occ0, 0);
    stall = '0; flush = '0;
    for (int i = 0; i < 4; i++) tick();
    chk("fl_ret", ret0, 0);

    // Asynchronous reset with payloads in flight.
    do_reset("r5");
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = 8'hC0 + 8'(i);
      tick();
    end
    in_valid = 1'b0; tick(); tick();
    #1; chk("mid_ov0_pre", ov0, 1); chk("mid_ret0_pre", ret0, 1);
    #2;
    do_reset("mid");
    tick(); tick();

    // Narrow retire counter wraps after 16.
    do_reset("r6");
    in_valid = 1'b1;
    for (int i = 0; i < 17; i++) begin
      in_data = 8'(i);
      tick();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    chk("wrap_ret0", ret0, 1);
    chk("wrap_ret1", ret1, 17);

    // Randomized traffic against the reference.
    do_reset("r7");
    for (int i = 0; i < 600; i++) begin
      if (i == 300) do_reset("rr");
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = 8'($urandom);
      stall     = 4'($urandom) & 4'($urandom) & 4'($urandom);
      flush     = 4'($urandom) & 4'($urandom) & 4'($urandom) & 4'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pipeline_stage_chain.md
PIPELINE_STAGE_CHAIN -- requirements
Module: pipeline_stage_chain

Interface
REQ-001 SHALL have parameter NUM_STAGES, default 4, number of register stages (IF/ID, ID/EX, EX/MEM, MEM/WB); legal range 1..16.
REQ-002 SHALL have parameter DATA_WIDTH, default 64, payload bits per stage.
REQ-003 SHALL have parameter COLLAPSE, default 0; 1 means invalid stages accept data even when downstream is blocked.
REQ-004 SHALL have parameter CNT_WIDTH, default 32, retire counter width.
REQ-005 SHALL have port clk, input, 1, single clock; all state changes on its rising edge.
REQ-006 SHALL have port reset, input, 1, asynchronous, active-high.
REQ-007 SHALL have port in_valid, input, 1, upstream offers in_data.
REQ-008 SHALL have port in_data, input, DATA_WIDTH, payload entering stage 0.
REQ-009 SHALL have port in_ready, output, 1, stage 0 accepts this cycle.
REQ-010 SHALL have port stall_i, input, NUM_STAGES, bit s holds stage s content in place.
REQ-011 SHALL have port flush_i, input, NUM_STAGES, bit s discards stage s content.
REQ-012 SHALL have port out_valid, output, 1, last stage presents a payload.
REQ-013 SHALL have port out_data, output, DATA_WIDTH, last stage payload.
REQ-014 SHALL have port out_ready, input, 1, consumer accepts.
REQ-015 SHALL have port occupancy_o, output, clog2(NUM_STAGES+1), count of valid stages.
REQ-016 SHALL have port retired_o, output, CNT_WIDTH, count of accepted outputs.

Function
REQ-017 Each stage s SHALL hold a valid bit v[s] and payload d[s].
REQ-018 go[s] SHALL be v[s] AND NOT stall_i[s] AND NOT flush_i[s] AND acc[s+1]; acc[NUM_STAGES] = out_ready.
REQ-019 acc[s] SHALL equal go[s] when v[s]=1; when v[s]=0, 1 if COLLAPSE=1, else acc[s+1].
REQ-020 in_ready SHALL equal acc[0]; no combinational path from in_valid to in_ready.
REQ-021 On acc[s], stage s SHALL load d[s-1] and v[s] <= (v[s-1] AND NOT stall_i[s-1] AND NOT flush_i[s-1]); for s=0, load in_data and in_valid.
REQ-022 When acc[s]=0, stage s SHALL keep v[s] and d[s] unchanged.
REQ-023 flush_i[s]=1 SHALL clear v[s] at the next edge, overriding stall_i[s] and any load into s.
REQ-024 A stalled valid stage SHALL pass a bubble (v=0) to stage s+1 when acc[s+1]=1; no payload is ever duplicated or dropped except by flush.
REQ-025 out_valid SHALL be v[N-1] AND NOT stall_i[N-1] AND NOT flush_i[N-1]; out_data = d[N-1].
REQ-026 Latency SHALL be exactly NUM_STAGES cycles from acceptance (in_valid AND in_ready) to out_valid with no stalls.
REQ-027 occupancy_o SHALL equal the registered popcount of v[], updated the same edge as v[].
REQ-028 retired_o SHALL increment by 1 on each edge with out_valid AND out_ready, wrapping modulo 2^CNT_WIDTH.
REQ-029 Sustained throughput SHALL be one payload per cycle with no stalls and out_ready=1.

Reset
REQ-030 reset SHALL immediately clear all v[], d[], occupancy_o, retired_o to 0; out_valid drops to 0 without a clock edge.
REQ-031 Reset mid-stream SHALL discard all in-flight payloads; the first edge after deassertion behaves as from empty.

Structure
REQ-032 Stage index constants (IF_ID=0, ID_EX=1, EX_MEM=2, MEM_WB=3) and the clog2 helper SHALL reside in shared package pipeline_pkg.
REQ-033 One sub-module pipeline_stage_cell (one valid+payload register with load/flush) SHALL be instantiated NUM_STAGES times via generate.

Verification
REQ-034 N=4, W=8, out_ready=1: 0x11,0x22,0x33 on consecutive cycles -> out_data 0x11,0x22,0x33 on cycles 4,5,6; retired_o=3.
REQ-035 0xA1 in stage 1, 0xA2 in stage 0, stall_i[1]=1 two cycles -> stage 1 holds 0xA1, stage 2 gets bubbles, in_ready=0, 0xA2 held.
REQ-036 out_ready=0, COLLAPSE=1: feed 0x55 then 3 more -> 0x55 reaches stage 3, occupancy_o=4, in_ready=0; COLLAPSE=0 -> in_ready=0 from the start, occupancy_o=0.
REQ-037 Stage 2 valid with stall_i[2]=1 and flush_i[2]=1 -> v[2]=0 next edge, occupancy_o decrements, payload never output.
REQ-038 Three valid payloads, reset asserted between edges -> out_valid=0 and occupancy_o=0 immediately, retired_o=0.
REQ-039 CNT_WIDTH=4, 17 payloads retired -> retired_o=1.
